// File: rtl/shift_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shift_sequencer: valid/ready front-end for a 16-bit logical-right barrel   |
// | shifter, adding rotate-right and out-of-range amounts. Option macro:       |
// | SHIFT_STATS_EN adds the op_count result counter.                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module shift_sequencer #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [4:0]        in_amt,
  input  logic              in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [WIDTH-1:0]  sh_in,
  output logic [3:0]        sh_ctrl,
  input  logic [WIDTH-1:0]  sh_out
`ifdef SHIFT_STATS_EN
  ,
  output logic [STAT_W-1:0] op_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS1 = 2'd1,
    S_PASS2 = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  if (WIDTH != 16 || STAT_W < 1) begin : g_bad_cfg
    $error("shift_sequencer: WIDTH must be 16 and STAT_W at least 1");
  end

  state_t           state_q;
  logic [WIDTH-1:0] opnd_q;
  logic             op_q;
  logic [3:0]       n_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] sh_in_q;
  logic [3:0]       sh_ctrl_q;

  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
    return r;
  endfunction

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sh_in     = sh_in_q;
  assign sh_ctrl   = sh_ctrl_q;

  // Rotate right by n = (x >> n) | rev(rev(x) >> (16 - n)); second pass supplies the wrapped bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      opnd_q      <= '0;
      op_q        <= 1'b0;
      n_q         <= 4'd0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sh_in_q     <= '0;
      sh_ctrl_q   <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (!in_op && in_amt[4]) begin
              out_data_q  <= '0;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              opnd_q    <= in_data;
              op_q      <= in_op;
              n_q       <= in_amt[3:0];
              sh_in_q   <= in_data;
              sh_ctrl_q <= in_amt[3:0];
              state_q   <= S_PASS1;
            end
          end
        end
        S_PASS1: begin
          acc_q <= sh_out;
          if (!op_q || (n_q == 4'd0)) begin
            out_data_q  <= sh_out;
            out_valid_q <= 1'b1;
            sh_in_q     <= '0;
            sh_ctrl_q   <= 4'd0;
            state_q     <= S_DONE;
          end else begin
            sh_in_q   <= rev(opnd_q);
            sh_ctrl_q <= 4'd0 - n_q;
            state_q   <= S_PASS2;
          end
        end
        S_PASS2: begin
          out_data_q  <= acc_q | rev(sh_out);
          out_valid_q <= 1'b1;
          sh_in_q     <= '0;
          sh_ctrl_q   <= 4'd0;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SHIFT_STATS_EN
  logic [STAT_W-1:0] op_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= '0;
    end else if (out_valid_q && out_ready && !(&op_count_q)) begin
      op_count_q <= op_count_q + 1'b1;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_shift_sequencer: randomized and directed bench for shift_sequencer,     |
// | with a behavioural shifter and reference model. Honours SHIFT_STATS_EN.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_shift_sequencer;

  localparam int STAT_W = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [4:0]  in_amt;
  logic        in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] sh_in;
  logic [3:0]  sh_ctrl;
  logic [15:0] sh_out;
`ifdef SHIFT_STATS_EN
  logic [STAT_W-1:0] op_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the external combinational shifter.
  assign sh_out = sh_in >> sh_ctrl;

  shift_sequencer #(.WIDTH(16), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sh_in(sh_in), .sh_ctrl(sh_ctrl), .sh_out(sh_out)
`ifdef SHIFT_STATS_EN
    , .op_count(op_count)
`endif
  );

  function automatic logic [15:0] ref_result(input logic [15:0] d, input logic [4:0] a, input logic op);
    logic [31:0] dd;
    if (!op) return (a >= 5'd16) ? 16'h0000 : (d >> a);
    dd = {d, d} >> (a % 16);
    return dd[15:0];
  endfunction

  function automatic int ref_latency(input logic [4:0] a, input logic op);
    if (!op && a >= 5'd16) return 1;
    if (op && (a % 16) != 0) return 3;
    return 2;
  endfunction

  // Driver only: issues one request from a negedge and reports what it observed.
  task automatic run_op(input logic [15:0] d, input logic [4:0] a, input logic op,
                        input bit release_now, output int lat, output logic [15:0] res,
                        output logic [15:0] si1, output logic [3:0] sc1,
                        output logic [15:0] si2, output logic [3:0] sc2);
    in_data = d; in_amt = a; in_op = op; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 16'($urandom); in_amt = 5'($urandom); in_op = 1'($urandom);
    lat = 1; si1 = sh_in; sc1 = sh_ctrl; si2 = '0; sc2 = '0;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin si2 = sh_in; sc2 = sh_ctrl; end
    end
    res = out_data;
    if (release_now) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    in_data = 16'hFFFF; in_amt = 5'd1; in_op = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    checks++; if ({sh_in, sh_ctrl} !== 20'h0) begin errors++; $display("FAIL reset_sh got %h/%h want 0/0", sh_in, sh_ctrl); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    in_valid = 1'b0; rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed;
    int lat; logic [15:0] res, si1, si2; logic [3:0] sc1, sc2;
    run_op(16'hB6F1, 5'd4, 1'b0, 1'b1, lat, res, si1, sc1, si2, sc2);
    checks++; if (sc1 !== 4'd4) begin errors++; $display("FAIL lsr_pass1_ctrl got %0d want 4", sc1); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL lsr_latency got %0d want 2", lat); end
    checks++; if (res !== 16'h0B6F) begin errors++; $display("FAIL lsr_result got %h want 0b6f", res); end
    run_op(16'h8001, 5'd1, 1'b1, 1'b1, lat, res, si1, sc1, si2, sc2);
    checks++; if (sc1 !== 4'd1) begin errors++; $display("FAIL ror_pass1_ctrl got %0d want 1", sc1); end
    checks++; if (si2 !== 16'h8001 || sc2 !== 4'd15) begin errors++; $display("FAIL ror_pass2 got %h/%0d want 8001/15", si2, sc2); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL ror_latency got %0d want 3", lat); end
    checks++; if (res !== 16'hC000) begin errors++; $display("FAIL ror_result got %h want c000", res); end
    run_op(16'hFFFF, 5'd20, 1'b0, 1'b1, lat, res, si1, sc1, si2, sc2);
    checks++; if (lat !== 1) begin errors++; $display("FAIL oor_latency got %0d want 1", lat); end
    checks++; if (res !== 16'h0000) begin errors++; $display("FAIL oor_result got %h want 0000", res); end
    checks++; if (sc1 !== 4'd0 || si1 !== 16'h0) begin errors++; $display("FAIL oor_shifter_idle got %h/%0d want 0/0", si1, sc1); end
    run_op(16'h1234, 5'd16, 1'b1, 1'b1, lat, res, si1, sc1, si2, sc2);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wrap_latency got %0d want 2", lat); end
    checks++; if (res !== 16'h1234) begin errors++; $display("FAIL wrap_result got %h want 1234", res); end
    checks++; if (sc1 !== 4'd0) begin errors++; $display("FAIL wrap_ctrl got %0d want 0", sc1); end
  endtask

  task automatic test_backpressure;
    int lat; logic [15:0] res, si1, si2; logic [3:0] sc1, sc2;
    run_op(16'h5A3C, 5'd3, 1'b1, 1'b0, lat, res, si1, sc1, si2, sc2);
    checks++; if (res !== ref_result(16'h5A3C, 5'd3, 1'b1)) begin errors++; $display("FAIL bp_result got %h want %h", res, ref_result(16'h5A3C, 5'd3, 1'b1)); end
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid; in_data = 16'($urandom); in_amt = 5'($urandom); in_op = 1'($urandom);
      @(negedge clk);
      checks++; if (out_data !== res || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold cycle %0d got %h/%b want %h/1", i, out_data, out_valid, res); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", i, in_ready); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b/%b want 1/0", in_ready, out_valid); end
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_ghost got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    in_data = 16'h8001; in_amt = 5'd1; in_op = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (sh_ctrl !== 4'd15) begin errors++; $display("FAIL rmid_in_pass2 got ctrl %0d want 15", sh_ctrl); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin errors++; $display("FAIL rmid_out got %b/%h want 0/0000", out_valid, out_data); end
    checks++; if (sh_in !== 16'h0 || sh_ctrl !== 4'd0) begin errors++; $display("FAIL rmid_sh got %h/%0d want 0/0", sh_in, sh_ctrl); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
    repeat (4) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale got %b want 0", out_valid); end
  endtask

  task automatic test_random;
    int lat; logic [15:0] d, res, si1, si2; logic [3:0] sc1, sc2; logic [4:0] a; logic op;
    for (int k = 0; k < 60; k++) begin
      d = 16'($urandom); a = 5'($urandom); op = 1'($urandom);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready op %0d got %b want 1", k, in_ready); end
      run_op(d, a, op, 1'b1, lat, res, si1, sc1, si2, sc2);
      checks++; if (res !== ref_result(d, a, op)) begin errors++; $display("FAIL rnd_result d=%h a=%0d op=%b got %h want %h", d, a, op, res, ref_result(d, a, op)); end
      checks++; if (lat !== ref_latency(a, op)) begin errors++; $display("FAIL rnd_latency a=%0d op=%b got %0d want %0d", a, op, lat, ref_latency(a, op)); end
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic [15:0] res, si1, si2; logic [3:0] sc1, sc2;
    logic [15:0] d [4] = '{16'hF00F, 16'h0001, 16'hAAAA, 16'h7FFE};
    logic [4:0]  a [4] = '{5'd31, 5'd15, 5'd0, 5'd9};
    logic        o [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      run_op(d[k], a[k], o[k], 1'b1, lat, res, si1, sc1, si2, sc2);
      checks++; if (res !== ref_result(d[k], a[k], o[k]) || lat !== ref_latency(a[k], o[k])) begin
        errors++; $display("FAIL b2b %0d got %h lat %0d want %h lat %0d", k, res, lat, ref_result(d[k], a[k], o[k]), ref_latency(a[k], o[k]));
      end
    end
  endtask

`ifdef SHIFT_STATS_EN
  task automatic test_stats;
    int lat; logic [15:0] res, si1, si2; logic [3:0] sc1, sc2;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    checks++; if (op_count !== '0) begin errors++; $display("FAIL stats_reset got %0d want 0", op_count); end
    for (int k = 0; k < 3; k++) run_op(16'($urandom), 5'($urandom), 1'($urandom), 1'b1, lat, res, si1, sc1, si2, sc2);
    checks++; if (op_count !== 3'd3) begin errors++; $display("FAIL stats_three got %0d want 3", op_count); end
    for (int k = 0; k < 6; k++) run_op(16'($urandom), 5'($urandom), 1'($urandom), 1'b1, lat, res, si1, sc1, si2, sc2);
    checks++; if (op_count !== 3'd7) begin errors++; $display("FAIL stats_saturate got %0d want 7", op_count); end
  endtask
`endif

  initial begin
    in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = 1'b0; out_ready = 1'b0; rst = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
`ifdef SHIFT_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
